serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that runs a single 1-bit add datapath (two cascaded half-add stages: sum = x^y, carry = x&y) over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Sits between an operand producer and a result consumer; trades latency for area in place of a WIDTH-bit parallel adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair (a, b, cin) valid
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow = (carry into MSB) ^ cout
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst sampled high): state=IDLE, bit counter=0, shift registers=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0.
- in_ready = (state==IDLE) & ~rst. It is combinational from state, with no dependence on in_valid.
- IDLE:
  - Accept when in_valid & in_ready at edge E0.
  - Latch a, b, cin into the A/B shift registers and the carry register.
  - Clear the counter and the sum register; go to RUN.
- RUN: at each edge E1..E_WIDTH:
  - Take x=A[0], y=B[0], c=carry.
  - Compute s = x^y^c and c' = (x&y) | (c&(x^y)), i.e. the OR of two half-add carries.
  - Shift A and B right by 1. Shift s into the MSB of the sum register, which shifts right.
  - Carry ← c'.
  - At the edge where counter == WIDTH-1:
    - Record the carry into the MSB (the carry register value before that edge) into ovf: ovf ← c ^ c'.
    - cout ← c'.
    - Go to DONE.
  - Otherwise, increment the counter.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_valid & out_ready: go to IDLE. out_valid drops next cycle. sum, cout and ovf keep their last values until the next acceptance clears sum.
- Latency: out_valid is high in the cycle after edge E_WIDTH, i.e. exactly WIDTH edges after the acceptance edge.
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE handshake, back in IDLE). There is no accept-while-DONE overlap.
- Boundary conditions:
  - in_valid in RUN/DONE is ignored, and operands are not sampled.
  - out_ready outside DONE has no effect.
  - out_valid held with out_ready low stalls indefinitely with stable outputs.
  - WIDTH=1: one RUN cycle; carry into MSB = cin.
  - Counter width is clog2(WIDTH) with a minimum of 1 bit; it must not wrap before WIDTH-1.
  - rst high in any state, including mid-RUN or in DONE with out_valid high: aborts on that edge. The partial result is discarded and the reset values above apply. A new operation may be accepted in the first cycle after rst falls.
  - rst and in_valid high on the same edge: reset wins, nothing is accepted.

Test Plan:
- Reset, then a=8'h00, b=8'h00, cin=0 -> out_valid exactly 8 edges after accept; sum=8'h00, cout=0, ovf=0; busy high throughout.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> in_ready=0, sum/cout/ovf stable, new operands not taken. Raise out_ready -> one-cycle handshake, IDLE, then the new operands are accepted.
- Assert rst for one cycle at bit 3 of a RUN -> next cycle out_valid=0, sum=0, busy=0, in_ready=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, ovf=0, 8 edges after accept.
- WIDTH=1 instance: all 8 (a, b, cin) combinations back-to-back -> sum/cout match the full-add truth table, ovf = cin ^ cout, latency 1 edge, issue interval 3 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: adds a WIDTH-bit operand pair one bit per clock,
// LSB first, through a single full-add cell built from two half-add stages.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_next_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             c1_s;
    logic             h1_s;
    logic             c2_s;
    logic             bit_s;
    logic             carry_next_s;
    logic             last_s;

    // Returns {carry, sum} of a single half-add stage.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full-add cell from two cascaded half-adds, plus the next sum register image.
    always_comb begin
        {c1_s, h1_s}  = half_add(a_r[0], b_r[0]);
        {c2_s, bit_s} = half_add(h1_s, carry_r);
        carry_next_s  = c1_s | c2_s;
        last_s        = (cnt_r == LAST_BIT);
        sum_next_s    = sum_r >> 1;
        sum_next_s[WIDTH-1] = bit_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand shift registers, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    sum_r   <= sum_next_s;
                    carry_r <= carry_next_s;
                    if (last_s) begin
                        // carry_r here is the carry into the MSB
                        cout_r <= carry_next_s;
                        ovf_r  <= carry_r ^ carry_next_s;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) & ~rst;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit and a 1-bit instance driven
// with hand-computed vectors; monitors compare each presented result.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         acc;
    } exp_t;

    logic       clk;
    int         cyc;
    int         nvec;
    int         nfail;
    exp_t       q8[$];
    exp_t       q1[$];
    bit         done1;

    logic       rst8, in_valid8, in_ready8, cin8, ov8, or8, cout8, ovf8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       rst1, in_valid1, in_ready1, cin1, ov1, or1, cout1, ovf1, busy1;
    logic [0:0] a1, b1, sum1;
    logic       ov8_prev, ov1_prev;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor for the 8-bit instance: checks latency and holds stability while stalled.
    initial ov8_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst8 && ov8) begin
            if (q8.size() == 0) begin
                chk("unexpected8", 1, 0);
            end else begin
                if (!ov8_prev) chk("lat8", cyc - q8[0].acc, 8);
                chk("sum8", sum8, q8[0].s);
                chk("cout8", cout8, q8[0].co);
                chk("ovf8", ovf8, q8[0].ov);
                if (or8) void'(q8.pop_front());
            end
        end
        ov8_prev = ov8;
    end

    // Result monitor for the 1-bit instance.
    initial ov1_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst1 && ov1) begin
            if (q1.size() == 0) begin
                chk("unexpected1", 1, 0);
            end else begin
                if (!ov1_prev) chk("lat1", cyc - q1[0].acc, 1);
                chk("sum1", sum1, q1[0].s);
                chk("cout1", cout1, q1[0].co);
                chk("ovf1", ovf1, q1[0].ov);
                if (or1) void'(q1.pop_front());
            end
        end
        ov1_prev = ov1;
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic [7:0] es, input logic eco, input logic eov);
        int   n = 0;
        bit   got = 1'b0;
        exp_t e;
        a8 = ia; b8 = ib; cin8 = ic; in_valid8 = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (in_ready8) begin
                e.s = es; e.co = eco; e.ov = eov; e.acc = cyc + 1;
                q8.push_back(e);
                got = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid8 = 1'b0;
        if (!got) chk("accept8_timeout", 0, 1);
    endtask

    task automatic wait8();
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            chk("busy8", busy8, 1);
            if (ov8) got = 1'b1;
            n++;
        end
        if (!got) chk("result8_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [7:0] es, input logic eco, input logic eov);
        issue8(ia, ib, ic, es, eco, eov);
        wait8();
    endtask

    // 8-bit directed sequence, then summary.
    initial begin
        nvec = 0; nfail = 0;
        rst8 = 1'b1; in_valid8 = 1'b0; or8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid8", ov8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_ready8", in_ready8, 0);
        @(posedge clk); #1;
        rst8 = 1'b0;
        @(negedge clk);
        chk("ready8", in_ready8, 1);
        @(posedge clk); #1;

        run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8(8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1);

        // Backpressure: result held while new operands wait at the input.
        or8 = 1'b0;
        issue8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        wait8();
        a8 = 8'h3C; b8 = 8'hC4; cin8 = 1'b0; in_valid8 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_ready8", in_ready8, 0);
            chk("stall_valid8", ov8, 1);
        end
        @(posedge clk); #1;
        or8 = 1'b1;
        issue8(8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0);
        wait8();

        // Abort mid-RUN at bit 3.
        issue8(8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("abort_valid8", ov8, 0);
        chk("abort_sum8", sum8, 0);
        chk("abort_busy8", busy8, 0);
        chk("abort_ready8", in_ready8, 1);
        @(posedge clk); #1;
        run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // Reset and in_valid on the same edge: nothing accepted.
        rst8 = 1'b1; in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        rst8 = 1'b0; in_valid8 = 1'b0;
        @(negedge clk);
        chk("rstwin_busy8", busy8, 0);
        chk("rstwin_valid8", ov8, 0);
        @(posedge clk); #1;

        begin
            int n = 0;
            while (!done1 && n < 2000) begin
                @(posedge clk);
                n++;
            end
            if (!done1) chk("w1_timeout", 0, 1);
        end
        @(negedge clk);
        chk("drain8", q8.size(), 0);
        chk("drain1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    // WIDTH=1 instance: full-add truth table back to back.
    initial begin
        logic [7:0] tsum, tcout, tovf;
        int         last_acc;
        done1 = 1'b0;
        tsum  = 8'b1001_0110;
        tcout = 8'b1110_1000;
        tovf  = 8'b0100_0010;
        last_acc = 0;
        rst1 = 1'b1; in_valid1 = 1'b0; or1 = 1'b1; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int         n;
            bit         got;
            exp_t       e;
            logic [2:0] v;
            v = i[2:0];
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; in_valid1 = 1'b1;
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                if (in_ready1) begin
                    e.s = {7'b0, tsum[i]}; e.co = tcout[i]; e.ov = tovf[i]; e.acc = cyc + 1;
                    q1.push_back(e);
                    if (i > 0) chk("interval1", e.acc - last_acc, 3);
                    last_acc = e.acc;
                    got = 1'b1;
                end
                @(posedge clk); #1;
                n++;
            end
            in_valid1 = 1'b0;
            if (!got) chk("accept1_timeout", 0, 1);
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                if (ov1) got = 1'b1;
                n++;
            end
            if (!got) chk("result1_timeout", 0, 1);
            @(posedge clk); #1;
        end
        done1 = 1'b1;
    end

endmodule
